// File: rtl/cop0_pkg.sv
// Shared CP0 definitions: register addresses, field positions, exception codes, reset values.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package cop0_pkg;

    // Register addresses as {rd, sel}
    localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] A_EBASE    = {5'd15, 3'd1};

    // Field positions
    localparam int IE_BIT    = 0;
    localparam int EXL_BIT   = 1;
    localparam int ERL_BIT   = 2;
    localparam int BEV_BIT   = 22;
    localparam int BD_BIT    = 31;
    localparam int TI_BIT    = 30;
    localparam int IP_HI     = 15;
    localparam int IP_LO     = 8;
    localparam int IP_HW_LO  = 10;
    localparam int IM_HI     = 15;
    localparam int IM_LO     = 8;
    localparam int EXC_HI    = 6;
    localparam int EXC_LO    = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0004;
    localparam logic [31:0] EBASE_RST_DEF  = 32'h8000_0000;
    localparam logic [31:0] ZERO_RST       = 32'h0000_0000;

    // Bits set in the mask take the new data, the rest keep the old value.
    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer: prescaler, Count, Compare and the timer-interrupt flag TI.
// Latency: writes and TI updates take effect on the next clk edge.
// Backpressure: none; write strobes are always accepted.
module cop0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  div;
    logic        wrap;
    logic [31:0] count_inc;

    assign wrap      = (div == DIV_LAST);
    assign count_inc = count + 32'd1;

    // Prescaler, Count, Compare and TI; Count writes restart the prescaler, Compare writes clear TI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= 4'd0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= count_wdata;
                div   <= 4'd0;
            end else if (wrap) begin
                count <= count_inc;
                div   <= 4'd0;
            end else begin
                div   <= div + 4'd1;
            end
            if (compare_we) begin
                compare <= compare_wdata;
            end
            if (compare_we) begin
                ti <= 1'b0;
            end else if (!count_we && wrap && (count_inc == compare)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cop0_regfile.sv
// Architectural CP0 register bank: masked MTC0 writes, MFC0 reads, exception/ERET commits, timer, interrupt flag.
// Latency: writes land on the next clk edge; rdata and int_pending are combinational from registered state.
// Backpressure: none; every commit is taken in the cycle it is presented. Timer enabled by macro COP0_TIMER_EN.
module cop0_regfile
    import cop0_pkg::*;
#(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF,
    parameter logic [31:0] EBASE_RST  = EBASE_RST_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] rdata,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        exc_bad_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] ebase_o,
    output logic        int_pending
);

    if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_div
        $error("COUNT_DIV must be in 1..16");
    end

    logic [31:0] status_q, cause_q, epc_q, badvaddr_q, ebase_q;
    logic [31:0] status_d, cause_d, epc_d, badvaddr_d, ebase_d;
    logic [31:0] cause_v;
    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  addr;
    logic        wr;

    assign addr = {rd, sel};
    // An exception commit swallows any MTC0 in the same cycle.
    assign wr   = we & ~exc_valid;

    // TI lives in the timer; cause_q[30] is held at 0 so the OR yields the architectural view.
    assign cause_v = cause_q | ({31'd0, ti} << TI_BIT);

`ifdef COP0_TIMER_EN
    cop0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .count_we      (wr && (addr == A_COUNT)),
        .count_wdata   (merge(count, wdata, wmask)),
        .compare_we    (wr && (addr == A_COMPARE)),
        .compare_wdata (merge(compare, wdata, wmask)),
        .count         (count),
        .compare       (compare),
        .ti            (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    // Next-state: MTC0 first, then exception or ERET on top, then hardware IP sampling.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ebase_d    = ebase_q;
        if (wr) begin
            case (addr)
                A_STATUS:   status_d   = merge(status_q, wdata, wmask);
                A_CAUSE:    cause_d    = merge(cause_q, wdata, wmask);
                A_EPC:      epc_d      = merge(epc_q, wdata, wmask);
                A_BADVADDR: badvaddr_d = merge(badvaddr_q, wdata, wmask);
                A_EBASE:    ebase_d    = merge(ebase_q, wdata, wmask);
                default:    ;
            endcase
        end
        if (exc_valid) begin
            cause_d[EXC_HI:EXC_LO] = exc_code;
            // A nested exception keeps the original return point.
            if (!status_q[EXL_BIT]) begin
                epc_d          = exc_epc;
                cause_d[BD_BIT] = exc_bd;
            end
            status_d[EXL_BIT] = 1'b1;
            if (exc_bad_we) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            if (status_d[ERL_BIT]) begin
                status_d[ERL_BIT] = 1'b0;
            end else begin
                status_d[EXL_BIT] = 1'b0;
            end
        end
        cause_d[IP_HI:IP_HW_LO] = {hw_int[5] | ti, hw_int[4:0]};
        cause_d[TI_BIT]         = 1'b0;
    end

    // Architectural register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q   <= STATUS_RST;
            cause_q    <= ZERO_RST;
            epc_q      <= ZERO_RST;
            badvaddr_q <= ZERO_RST;
            ebase_q    <= EBASE_RST;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ebase_q    <= ebase_d;
        end
    end

    // MFC0 read mux; shows pre-edge values, unimplemented addresses read 0.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_BADVADDR: rdata = badvaddr_q;
            A_COUNT:    rdata = count;
            A_COMPARE:  rdata = compare;
            A_STATUS:   rdata = status_q;
            A_CAUSE:    rdata = cause_v;
            A_EPC:      rdata = epc_q;
            A_EBASE:    rdata = ebase_q;
            default:    rdata = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_v;
    assign epc_o       = epc_q;
    assign ebase_o     = ebase_q;
    assign int_pending = status_q[IE_BIT] & ~status_q[EXL_BIT] & ~status_q[ERL_BIT]
                       & (|(cause_v[IP_HI:IP_LO] & status_q[IM_HI:IM_LO]));

endmodule

// File: tb/tb_cop0_regfile.sv
// Directed bench for cop0_regfile: vector table plus hand-written timer and reset sequences.
module tb_cop0_regfile;
    import cop0_pkg::*;

    localparam int C_STATUS = 0;
    localparam int C_CAUSE  = 1;
    localparam int C_EPC    = 2;
    localparam int C_EBASE  = 3;
    localparam int C_INT    = 4;
    localparam int C_RDATA  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] wdata, wmask, rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd, exc_bad_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status_o, cause_o, epc_o, ebase_o;
    logic        int_pending;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bad_we;
        logic [31:0] bva;
        logic        eret;
        logic [5:0]  hw;
        int          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    cop0_regfile #(.COUNT_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .rd(rd), .sel(sel),
        .wdata(wdata), .wmask(wmask), .rdata(rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_bd(exc_bd), .exc_bad_we(exc_bad_we), .exc_badvaddr(exc_badvaddr),
        .eret(eret), .hw_int(hw_int),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
        .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic w, input logic [4:0] r,
                                input logic [2:0] s, input logic [31:0] wd, input logic [31:0] wm,
                                input logic e, input logic [4:0] c, input logic [31:0] ep,
                                input logic b, input logic bw, input logic [31:0] bv,
                                input logic er, input logic [5:0] h, input int ck,
                                input logic [31:0] ex);
        vec_t v;
        v.name = name; v.we = w; v.rd = r; v.sel = s; v.wdata = wd; v.wmask = wm;
        v.exc = e; v.code = c; v.epc = ep; v.bd = b; v.bad_we = bw; v.bva = bv;
        v.eret = er; v.hw = h; v.chk = ck; v.exp = ex;
        return v;
    endfunction

    function automatic logic [31:0] pick(input int c);
        case (c)
            C_STATUS: return status_o;
            C_CAUSE:  return cause_o;
            C_EPC:    return epc_o;
            C_EBASE:  return ebase_o;
            C_INT:    return {31'd0, int_pending};
            default:  return rdata;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_strobes();
        we = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_bad_we = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        we = v.we; rd = v.rd; sel = v.sel; wdata = v.wdata; wmask = v.wmask;
        exc_valid = v.exc; exc_code = v.code; exc_epc = v.epc; exc_bd = v.bd;
        exc_bad_we = v.bad_we; exc_badvaddr = v.bva; eret = v.eret; hw_int = v.hw;
        @(posedge clk);
        #1;
        clear_strobes();
        #1;
        check(v.name, pick(v.chk), v.exp);
    endtask

    task automatic mtc(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; rd = r; sel = s; wdata = d; wmask = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        clear_strobes();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_strobes();
        rd = 5'd0; sel = 3'd0; wdata = 32'd0; wmask = 32'd0;
        exc_code = 5'd0; exc_epc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0;
        hw_int = 6'd0;

        //      name           we rd  sel wdata          wmask          ex code      epc            bd bw bva            er hw        chk       expected
        tbl.push_back(mk("stat_mask",   1, 12, 0, 32'hFFFF_FFFF, 32'h1040_FF17, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h1040_FF17));
        tbl.push_back(mk("stat_clr",    1, 12, 0, 32'h0000_0000, 32'h0000_0006, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h1040_FF11));
        tbl.push_back(mk("rd_status",   0, 12, 0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_RDATA,  32'h1040_FF11));
        tbl.push_back(mk("exc1_cause",  0, 0,  0, 32'h0,         32'h0,         1, EXC_OV,  32'hBFC0_0100, 1, 0, 32'h0,         0, 6'h00, C_CAUSE,  32'h8000_0030));
        tbl.push_back(mk("exc1_epc",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_EPC,    32'hBFC0_0100));
        tbl.push_back(mk("exc1_exl",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h1040_FF13));
        tbl.push_back(mk("exc2_cause",  0, 0,  0, 32'h0,         32'h0,         1, EXC_ADEL,32'h0000_1234, 0, 0, 32'h0,         0, 6'h00, C_CAUSE,  32'h8000_0010));
        tbl.push_back(mk("exc2_epc",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_EPC,    32'hBFC0_0100));
        tbl.push_back(mk("badvaddr",    0, 8,  0, 32'h0,         32'h0,         1, EXC_ADES,32'h0000_5678, 0, 1, 32'hDEAD_BEEF, 0, 6'h00, C_RDATA,  32'hDEAD_BEEF));
        tbl.push_back(mk("eret_exl",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         1, 6'h00, C_STATUS, 32'h1040_FF11));
        tbl.push_back(mk("stat_set",    1, 12, 0, 32'h0000_0006, 32'h0000_0006, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h1040_FF17));
        tbl.push_back(mk("eret_erl",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         1, 6'h00, C_STATUS, 32'h1040_FF13));
        tbl.push_back(mk("eret_exl2",   0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         1, 6'h00, C_STATUS, 32'h1040_FF11));
        tbl.push_back(mk("exc_over_we", 1, 14, 0, 32'h0000_DEAD, 32'hFFFF_FFFF, 1, EXC_SYS, 32'h0000_2000, 0, 0, 32'h0,         0, 6'h00, C_EPC,    32'h0000_2000));
        tbl.push_back(mk("we_eret_epc", 1, 14, 0, 32'h0000_3000, 32'hFFFF_FFFF, 0, 5'd0,    32'h0,         0, 0, 32'h0,         1, 6'h00, C_RDATA,  32'h0000_3000));
        tbl.push_back(mk("we_eret_st",  0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h1040_FF11));
        tbl.push_back(mk("unimpl_rd10", 1, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_RDATA,  32'h0000_0000));
        tbl.push_back(mk("unimpl_15_0", 1, 15, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_RDATA,  32'h0000_0000));
        tbl.push_back(mk("ebase_mask",  1, 15, 1, 32'h0000_1000, 32'h3FFF_F000, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_EBASE,  32'h8000_1000));
        tbl.push_back(mk("zero_mask",   1, 14, 0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_EPC,    32'h0000_3000));
        tbl.push_back(mk("sw_ip_set",   1, 13, 0, 32'h0000_0300, 32'h0000_0300, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_CAUSE,  32'h0000_0320));
        tbl.push_back(mk("sw_ip_int",   0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_INT,    32'h0000_0001));
        tbl.push_back(mk("sw_ip_clr",   1, 13, 0, 32'h0000_0000, 32'h0000_0300, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_INT,    32'h0000_0000));
        tbl.push_back(mk("stat_ie_im2", 1, 12, 0, 32'h0000_0401, 32'hFFFF_FFFF, 0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_STATUS, 32'h0000_0401));
        tbl.push_back(mk("hw_int_on",   0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h01, C_INT,    32'h0000_0001));
        tbl.push_back(mk("int_exc",     0, 0,  0, 32'h0,         32'h0,         1, EXC_INT, 32'h0000_4000, 0, 0, 32'h0,         0, 6'h01, C_INT,    32'h0000_0000));
        tbl.push_back(mk("int_eret",    0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         1, 6'h01, C_INT,    32'h0000_0001));
        tbl.push_back(mk("hw_int_off",  0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_INT,    32'h0000_0000));
        tbl.push_back(mk("hw5_ip7",     0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h20, C_CAUSE,  32'h0000_8000));
        tbl.push_back(mk("hw5_off",     0, 0,  0, 32'h0,         32'h0,         0, 5'd0,    32'h0,         0, 0, 32'h0,         0, 6'h00, C_CAUSE,  32'h0000_0000));

        // Reset values after release
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_status", status_o, 32'h0040_0004);
        check("rst_ebase",  ebase_o,  32'h8000_0000);
        check("rst_cause",  cause_o,  32'h0000_0000);
        check("rst_int",    {31'd0, int_pending}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

`ifdef COP0_TIMER_EN
        // Compare=5, Count=0: TI rises exactly 10 clocks after the Count write.
        mtc(5'd11, 3'd0, 32'd5);
        mtc(5'd9,  3'd0, 32'd0);
        repeat (9) tick();
        check("ti_before", {31'd0, cause_o[30]}, 32'h0);
        tick();
        check("ti_set", {31'd0, cause_o[30]}, 32'h1);
        rd = 5'd9; sel = 3'd0;
        #1;
        check("count_match", rdata, 32'd5);
        tick();
        check("ti_ip7", {31'd0, cause_o[15]}, 32'h1);
        mtc(5'd11, 3'd0, 32'h0000_0100);
        check("ti_clear", {31'd0, cause_o[30]}, 32'h0);
        repeat (3) tick();
        rd = 5'd9; sel = 3'd0;
        #1;
        check("count_running", rdata, 32'd7);
`else
        // Without the timer, Count/Compare are read-as-zero and TI never rises.
        mtc(5'd9, 3'd0, 32'h0000_0055);
        rd = 5'd9; sel = 3'd0;
        #1;
        check("count_off", rdata, 32'h0);
        mtc(5'd11, 3'd0, 32'h0000_0001);
        rd = 5'd11; sel = 3'd0;
        #1;
        check("compare_off", rdata, 32'h0);
        repeat (12) tick();
        check("ti_off", {31'd0, cause_o[30]}, 32'h0);
`endif

        // Asynchronous reset mid-run takes effect without a clock edge.
        @(negedge clk);
        #2;
        rd = 5'd9; sel = 3'd0;
        reset_n = 1'b0;
        #1;
        check("arst_count",  rdata,    32'h0);
        check("arst_status", status_o, 32'h0040_0004);
        check("arst_ebase",  ebase_o,  32'h8000_0000);
        check("arst_epc",    epc_o,    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cop0_regfile.md
Name: cop0_regfile

Overview:
- Architectural CP0 register bank. Sits directly downstream of the CP0 write-mask filter.
- Applies MTC0 writes under the filter's per-register write mask and serves MFC0 reads.
- Takes exception/ERET commits from the writeback stage.
- Runs the Count/Compare timer and exports Status/Cause/EPC/EBase plus an interrupt-pending flag to the exception unit.

Parameters:
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks (1..16).
- STATUS_RST, 32'h0040_0004: Status reset value (BEV=1, ERL=1).
- EBASE_RST, 32'h8000_0000: EBase reset value.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- we  in  1  MTC0 commit
- rd  in  5  CP0 register number (read and write)
- sel  in  3  CP0 select
- wdata  in  32  MTC0 data
- wmask  in  32  write mask from filter; 1 = bit writable
- rdata  out  32  MFC0 data; combinational from rd/sel
- exc_valid  in  1  exception commit
- exc_code  in  5  Cause.ExcCode value
- exc_epc  in  32  faulting PC
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_bad_we  in  1  update BadVAddr
- exc_badvaddr  in  32  bad address
- eret  in  1  ERET commit
- hw_int  in  6  hardware interrupt lines, level-sensitive
- status_o  out  32  Status
- cause_o  out  32  Cause
- epc_o  out  32  EPC
- ebase_o  out  32  EBase
- int_pending  out  1  interrupt pending

Behaviour:
- Implemented registers (rd,sel):
  - BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0), EBase (15,1).
  - Any other address reads 0; writes to it are ignored.
- Reset (async, reset_n=0), all outputs take the reset values at once:
  - Status=STATUS_RST, EBase=EBASE_RST.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Divider=0, TI=0, int_pending=0.
- MTC0 write, on the clk edge when we=1 and exc_valid=0: reg <= (reg & ~wmask) | (wdata & wmask). The mask is used exactly as given; this block applies no mask of its own.
- Exception (exc_valid=1) has priority over we; the MTC0 is dropped. On the edge:
  - Cause.ExcCode[6:2] <= exc_code.
  - If Status.EXL=0: EPC <= exc_epc and Cause.BD[31] <= exc_bd.
  - If Status.EXL=1: EPC and BD are held.
  - Status.EXL[1] <= 1.
  - If exc_bad_we=1: BadVAddr <= exc_badvaddr.
- ERET (eret=1, exc_valid=0):
  - If Status.ERL=1, clear ERL; otherwise clear EXL.
  - If we is also asserted in the same cycle, the MTC0 applies first and the ERET clear is applied on top of it.
- Interrupts:
  - Cause.IP[15:10] <= {hw_int[5]|TI, hw_int[4:0]}, registered every cycle.
  - Software IP[9:8] is writable only via MTC0.
  - TI is Cause[30].
  - int_pending = IE & ~EXL & ~ERL & |(Cause.IP & Status.IM). It is combinational from registered state.
- Timer:
  - The divider counts 0..COUNT_DIV-1; Count increments when the divider wraps. Count wraps 32'hFFFF_FFFF -> 0.
  - TI sets on the edge where the incremented Count equals Compare.
  - A write to Compare clears TI and has priority over a same-cycle match.
  - A write to Count loads the value and resets the divider to 0.
  - No increment happens in a cycle where Count is written.
- Read:
  - rdata shows pre-edge register values; a write in the same cycle is not bypassed.
  - Reads have no side effects.

Optional Feature:
- Macro: COP0_TIMER_EN.
- Defined: Count/Compare/TI behave as above.
- Undefined:
  - Count and Compare read 0 and writes to them are ignored.
  - TI is forced to 0 and IP7 = hw_int[5].
  - No divider logic is synthesised.

Decomposition:
- Shared package cop0_pkg holds:
  - localparams for each (rd,sel) pair;
  - bit-position localparams for EXL, ERL, IE, BEV, BD, TI, and the IP/IM/ExcCode ranges;
  - an exception-code enum (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12);
  - reset-value constants.
- Sub-module cop0_timer: holds the divider, Count, Compare and TI. Interface: count/compare write strobes and data in; count, compare, ti out.

Test Plan:
- Reset: release reset_n -> Status=32'h0040_0004, EBase=32'h8000_0000, Cause=0, int_pending=0.
- Masked write: MTC0 Status wdata=32'hFFFF_FFFF, wmask=32'h1040_FF17 -> Status=32'h1040_FF17 (BEV held at 1).
- Nested exception:
  - exc_valid, exc_code=12, exc_epc=32'hBFC0_0100, exc_bd=1 with EXL=0 -> Cause[6:2]=12, BD=1, EPC=32'hBFC0_0100, EXL=1.
  - A second exception (code 4, epc 32'h1234) -> EPC unchanged, ExcCode=4.
- Timer (COUNT_DIV=2): Compare=5, Count=0 written -> TI sets after 10 clocks and Cause.IP7=1. MTC0 Compare -> TI clears on the next edge.
- Interrupt: Status=32'h0000_0401 (IE=1, IM2=1), hw_int=6'b000001 -> int_pending=1 one clock later. Exception -> EXL=1 -> int_pending=0. ERET -> int_pending=1.
- Priority: exc_valid and we (EPC write 32'hDEAD) in the same cycle -> EPC=exc_epc, MTC0 dropped. Assert reset_n=0 mid-count -> Count=0 immediately.
